// File: rtl/rf_wb_arbiter.sv
// Write-back controller: round-robin arbitration of ALU/LSU onto the single register-file
// write port, one registered write stage, and a per-register pending-write scoreboard.
module rf_wb_arbiter #(
    parameter int unsigned DW = 32,
    parameter int unsigned AW = 5
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          hold,
    input  logic          a_valid,
    output logic          a_ready,
    input  logic [AW-1:0] a_addr,
    input  logic [DW-1:0] a_data,
    input  logic          b_valid,
    output logic          b_ready,
    input  logic [AW-1:0] b_addr,
    input  logic [DW-1:0] b_data,
    input  logic          rsv_valid,
    input  logic [AW-1:0] rsv_addr,
    input  logic [AW-1:0] rs1_addr,
    input  logic [AW-1:0] rs2_addr,
    output logic          rs1_busy,
    output logic          rs2_busy,
    output logic          rf_we,
    output logic [31:0]   rf_waddr,
    output logic [DW-1:0] rf_wdata,
    output logic          sb_err
);

    localparam int unsigned NReg = 1 << AW;

    logic            r_last;
    logic            r_we;
    logic [AW-1:0]   r_waddr;
    logic [DW-1:0]   r_wdata;
    logic [NReg-1:0] r_busy;
    logic            r_sb_err;

    logic            w_grant_a;
    logic            w_grant_b;
    logic            w_xfer;
    logic [AW-1:0]   w_addr;
    logic [DW-1:0]   w_data;
    logic            w_set;
    logic            w_err;
    logic [NReg-1:0] w_busy_d;

    // r_last=1 means B was granted most recently, so A wins a tie.
    always_comb begin
        w_grant_a = 1'b0;
        w_grant_b = 1'b0;
        if (rst_n && !hold) begin
            w_grant_a = a_valid && (!b_valid || r_last);
            w_grant_b = b_valid && (!a_valid || !r_last);
        end
        w_xfer = w_grant_a || w_grant_b;
        w_addr = w_grant_a ? a_addr : b_addr;
        w_data = w_grant_a ? a_data : b_data;
    end

    assign a_ready = w_grant_a;
    assign b_ready = w_grant_b;

    always_comb begin
        w_set    = rsv_valid && (rsv_addr != '0);
        w_err    = w_set && r_busy[rsv_addr] && !(r_we && (r_waddr == rsv_addr));
        w_busy_d = r_busy;
        if (r_we) begin
            w_busy_d[r_waddr] = 1'b0;
        end
        // Set after clear so a same-edge reservation wins.
        if (w_set) begin
            w_busy_d[rsv_addr] = 1'b1;
        end
        w_busy_d[0] = 1'b0;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_last   <= 1'b1;
            r_we     <= 1'b0;
            r_waddr  <= '0;
            r_wdata  <= '0;
            r_busy   <= '0;
            r_sb_err <= 1'b0;
        end else begin
            if (w_xfer) begin
                r_last <= w_grant_b;
            end
            r_we <= w_xfer && (w_addr != '0);
            if (w_xfer && (w_addr != '0)) begin
                r_waddr <= w_addr;
                r_wdata <= w_data;
            end
            r_busy   <= w_busy_d;
            r_sb_err <= r_sb_err | w_err;
        end
    end

    assign rs1_busy = (rs1_addr != '0) && r_busy[rs1_addr];
    assign rs2_busy = (rs2_addr != '0) && r_busy[rs2_addr];
    assign rf_we    = r_we;
    assign rf_waddr = {{(32 - AW){1'b0}}, r_waddr};
    assign rf_wdata = r_wdata;
    assign sb_err   = r_sb_err;

endmodule
